// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encodings, default sync marker,
// maximum frame length and the LEN-byte decoding helper.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN_MAX     = 256;
    localparam int         CNT_W             = 9;

    // A LEN byte of zero encodes a full 256-byte image.
    function automatic logic [CNT_W-1:0] frame_count(input logic [7:0] len);
        return (len == 8'd0) ? CNT_W'(FRAME_LEN_MAX) : {1'b0, len};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program loader.
// The master modport is the loader's view; the slave modport is the surrounding top level.
interface prog_loader_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;

    modport master (
        input  rx_data,
        input  rx_valid,
        output mem_we,
        output mem_addr,
        output mem_din
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_din
    );

endinterface

// File: rtl/prog_loader_gap_timer.sv
// loader_gap_timer: inter-byte gap counter used by prog_loader when LOADER_TIMEOUT_EN is defined.
// Counts enabled cycles since the last clear and flags expiry at TIMEOUT_CYCLES-1.
module loader_gap_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_mclk,
    input  logic i_clr_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Saturates at LAST so a held expiry cannot wrap back to zero.
    always_ff @(posedge i_mclk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_cnt <= '0;
        end else if (i_clear || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: writes a framed byte-stream image into instruction RAM and holds the CPU while loading.
// Define LOADER_TIMEOUT_EN to abort a frame whose inter-byte gap reaches TIMEOUT_CYCLES.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int            AW             = 8,
    parameter int            DW             = 8,
    parameter logic [DW-1:0] SYNC_BYTE      = DW'(SYNC_BYTE_DEFAULT),
    parameter int            BASE_ADDR      = 0,
    parameter int            TIMEOUT_CYCLES = 5_000_000
) (
    input  logic           i_mclk,
    input  logic           i_clr_n,
    prog_loader_if.master  bus,
    output logic           o_cpu_hold,
    output logic           o_done,
    output logic           o_err
);

    localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

    loader_state_t  r_state;
    logic           r_we;
    logic [DW-1:0]  r_din;
    logic [AW-1:0]  r_mem_addr;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_sum;
    logic [CNT_W-1:0] r_count;
    logic           r_hold;
    logic           r_done;
    logic           r_err;

    loader_state_t  w_state_nxt;
    logic           w_we_nxt;
    logic [DW-1:0]  w_din_nxt;
    logic [AW-1:0]  w_mem_addr_nxt;
    logic [AW-1:0]  w_addr_nxt;
    logic [DW-1:0]  w_sum_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic           w_hold_nxt;
    logic           w_done_nxt;
    logic           w_err_nxt;

    logic           w_is_sync;
    logic [DW-1:0]  w_sum_chk;
    logic           w_expire;

    assign w_is_sync = (bus.rx_data == SYNC_BYTE);
    assign w_sum_chk = r_sum + bus.rx_data;

`ifdef LOADER_TIMEOUT_EN
    logic w_in_frame;

    assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);

    loader_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .i_mclk   (i_mclk),
        .i_clr_n  (i_clr_n),
        .i_clear  (bus.rx_valid),
        .i_en     (w_in_frame),
        .o_expire (w_expire)
    );
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_expire         = 1'b0;
`endif

    // Expiry takes priority over a byte arriving in the same cycle, which is dropped.
    always_comb begin
        w_state_nxt    = r_state;
        w_we_nxt       = 1'b0;
        w_din_nxt      = r_din;
        w_mem_addr_nxt = r_mem_addr;
        w_addr_nxt     = r_addr;
        w_sum_nxt      = r_sum;
        w_count_nxt    = r_count;
        w_hold_nxt     = r_hold;
        w_done_nxt     = r_done;
        w_err_nxt      = r_err;

        if (w_expire) begin
            w_state_nxt = ST_ERR;
            w_err_nxt   = 1'b1;
        end else if (bus.rx_valid) begin
            unique case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_is_sync) begin
                        w_state_nxt    = ST_LEN;
                        w_hold_nxt     = 1'b1;
                        w_done_nxt     = 1'b0;
                        w_err_nxt      = 1'b0;
                        w_addr_nxt     = BASE;
                        w_mem_addr_nxt = BASE;
                        w_sum_nxt      = '0;
                    end
                end
                ST_LEN: begin
                    w_count_nxt = frame_count(bus.rx_data[7:0]);
                    w_state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    w_we_nxt       = 1'b1;
                    w_din_nxt      = bus.rx_data;
                    w_mem_addr_nxt = r_addr;
                    w_addr_nxt     = r_addr + 1'b1;
                    w_sum_nxt      = w_sum_chk;
                    w_count_nxt    = r_count - 1'b1;
                    if (r_count == CNT_W'(1)) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (w_sum_chk == '0) begin
                        w_state_nxt = ST_DONE;
                        w_hold_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_ERR;
                        w_err_nxt   = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_mclk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_din      <= '0;
            r_mem_addr <= BASE;
            r_addr     <= BASE;
            r_sum      <= '0;
            r_count    <= '0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_we       <= w_we_nxt;
            r_din      <= w_din_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_addr     <= w_addr_nxt;
            r_sum      <= w_sum_nxt;
            r_count    <= w_count_nxt;
            r_hold     <= w_hold_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.mem_we   = r_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_din;
    assign o_cpu_hold   = r_hold;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule
